sorted_ram_loader: RTL and testbench

- Upstream feeder for the binary-search datapath.
- Accepts a stream of unsorted values over a valid/ready handshake and keeps them in an internal DEPTH x VAL_WIDTH array in ascending order, using one-element-per-cycle insertion.
- Exposes a synchronous read port that the search datapath uses in place of its pre-initialised RAM.
- Unused slots read as all-ones, so a full-range binary search over addresses 0..DEPTH-1 always sees a sorted array.

---
 rtl/sorted_ram_loader.sv | 82 ++++++++
 tb/tb_sorted_ram_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_ram_loader.sv
// Insertion-sorted value store with a 1-cycle registered read port; an insert of a value with s larger
// entries completes s+1 edges after accept. in_ready drops while shifting, while full, and during clear.
module sorted_ram_loader #(
    parameter int VAL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [VAL_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [VAL_WIDTH-1:0]  rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic [VAL_WIDTH-1:0]    mem [DEPTH];
    logic [VAL_WIDTH-1:0]    val_reg;
    logic [ADDR_WIDTH:0]     p;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [ADDR_WIDTH-1:0]   prev_idx;
    logic                    shift_more;

    // p never reaches DEPTH while shifting, since accept is blocked at full
    assign wr_idx     = p[ADDR_WIDTH-1:0];
    assign prev_idx   = wr_idx - IDX_ONE;
    assign shift_more = (p != '0) && (mem[prev_idx] > val_reg);

    // count can only reach DEPTH, so its top bit alone signals full
    assign full     = count[ADDR_WIDTH];
    assign busy     = (state == SHIFT);
    assign in_ready = reset_n && (state == IDLE) && !full && !clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
            count   <= '0;
            state   <= IDLE;
            p       <= '0;
            val_reg <= '0;
            rd_data <= '1;
        end else begin
            rd_data <= mem[rd_addr];
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
                count <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            val_reg <= in_data;
                            p       <= count;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // strict compare keeps a new value behind existing equal ones
                        if (shift_more) begin
                            mem[wr_idx] <= mem[prev_idx];
                            p           <= p - CNT_ONE;
                        end else begin
                            mem[wr_idx] <= val_reg;
                            count       <= count + CNT_ONE;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sorted_ram_loader.sv
// Directed bench for sorted_ram_loader: reset, ordering, duplicates, full, clear and async reset.
module tb_sorted_ram_loader;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clear;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] count;
    logic       full;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sorted_ram_loader #(.VAL_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .clear    (clear),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    // Waits for in_ready, performs one accept, returns edges from accept until busy drops.
    task automatic do_insert(input logic [7:0] v, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        n   = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        lat = n;
        if (busy) ok = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        n_checks++;
        if (rd_data !== 8'hFF) begin n_fail++; $display("FAIL reset_rd_data: got %h want ff", rd_data); end
        #2 reset_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready); end
        n_checks++;
        if (count !== 6'd0 || full !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: count=%0d full=%b busy=%b want 0/0/0", count, full, busy);
        end
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d);
            n_checks++;
            if (d !== 8'hFF) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want ff", a, d); end
        end
    endtask

    task automatic test_insert_basic();
        logic [7:0] vals [3]  = '{8'd30, 8'd10, 8'd20};
        int         lats [3]  = '{1, 2, 2};
        logic [7:0] exp  [4]  = '{8'd10, 8'd20, 8'd30, 8'hFF};
        logic [7:0] d;
        int lat;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_insert(vals[i], lat, ok);
            n_checks++;
            if (!ok || lat != lats[i]) begin
                n_fail++; $display("FAIL basic_latency[%0d]: got %0d (ok=%b) want %0d", i, lat, ok, lats[i]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd(5'(a), d);
            n_checks++;
            if (d !== exp[a]) begin n_fail++; $display("FAIL basic_read[%0d]: got %h want %h", a, d, exp[a]); end
        end
        n_checks++;
        if (count !== 6'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", count); end
    endtask

    task automatic test_duplicates();
        logic [7:0] vals [4] = '{8'd5, 8'd5, 8'd3, 8'd5};
        int         lats [4] = '{1, 1, 3, 1};
        logic [7:0] exp  [5] = '{8'd3, 8'd5, 8'd5, 8'd5, 8'hFF};
        logic [7:0] d;
        int lat;
        bit ok;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            do_insert(vals[i], lat, ok);
            n_checks++;
            if (!ok || lat != lats[i]) begin
                n_fail++; $display("FAIL dup_latency[%0d]: got %0d (ok=%b) want %0d", i, lat, ok, lats[i]);
            end
        end
        for (int a = 0; a < 5; a++) begin
            rd(5'(a), d);
            n_checks++;
            if (d !== exp[a]) begin n_fail++; $display("FAIL dup_read[%0d]: got %h want %h", a, d, exp[a]); end
        end
        n_checks++;
        if (count !== 6'd4) begin n_fail++; $display("FAIL dup_count: got %0d want 4", count); end
    endtask

    task automatic test_full();
        logic [7:0] d;
        int lat;
        bit ok;
        int bad = 0;
        do_clear();
        for (int v = 31; v >= 0; v--) begin
            if (v == 0) begin
                n_checks++;
                if (count !== 6'd31 || full !== 1'b0) begin
                    n_fail++; $display("FAIL full_before_last: count=%0d full=%b want 31/0", count, full);
                end
            end
            do_insert(8'(v), lat, ok);
            if (!ok || lat != 32 - v) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL full_latencies: %0d wrong want 0", bad); end
        n_checks++;
        if (lat != 32) begin n_fail++; $display("FAIL full_last_latency: got %0d want 32", lat); end
        n_checks++;
        if (count !== 6'd32 || full !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_status: count=%0d full=%b in_ready=%b want 32/1/0", count, full, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || count !== 6'd32) begin
            n_fail++; $display("FAIL full_ignore: in_ready=%b busy=%b count=%0d want 0/0/32", in_ready, busy, count);
        end
        in_valid = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d);
            n_checks++;
            if (d !== 8'(a)) begin n_fail++; $display("FAIL full_read[%0d]: got %h want %h", a, d, 8'(a)); end
        end
    endtask

    task automatic test_clear_mid_shift();
        logic [7:0] d;
        int lat;
        bit ok;
        do_clear();
        do_insert(8'd10, lat, ok);
        do_insert(8'd20, lat, ok);
        do_insert(8'd30, lat, ok);
        in_valid = 1'b1;
        in_data  = 8'd1;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_before: got %b want 1", busy); end
        clear = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
        tick();
        clear = 1'b0;
        n_checks++;
        if (count !== 6'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_status: count=%0d busy=%b want 0/0", count, busy);
        end
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d);
            n_checks++;
            if (d !== 8'hFF) begin n_fail++; $display("FAIL clear_read[%0d]: got %h want ff", a, d); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        int lat;
        bit ok;
        do_clear();
        do_insert(8'd10, lat, ok);
        do_insert(8'd20, lat, ok);
        rd_addr = 5'd0;
        in_valid = 1'b1;
        in_data  = 8'd1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 6'd0 || busy !== 1'b0 || full !== 1'b0 || in_ready !== 1'b0 || rd_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d busy=%b full=%b in_ready=%b rd_data=%h want 0/0/0/0/ff",
                     count, busy, full, in_ready, rd_data);
        end
        #2 reset_n = 1'b1;
        tick();
        do_insert(8'd42, lat, ok);
        n_checks++;
        if (!ok || lat != 1) begin n_fail++; $display("FAIL async_insert_latency: got %0d (ok=%b) want 1", lat, ok); end
        rd(5'd0, d);
        n_checks++;
        if (d !== 8'd42) begin n_fail++; $display("FAIL async_read0: got %h want 2a", d); end
        rd(5'd1, d);
        n_checks++;
        if (d !== 8'hFF) begin n_fail++; $display("FAIL async_read1: got %h want ff", d); end
        n_checks++;
        if (count !== 6'd1) begin n_fail++; $display("FAIL async_count: got %0d want 1", count); end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        rd_addr  = '0;
        test_reset();
        test_insert_basic();
        test_duplicates();
        test_full();
        test_clear_mid_shift();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
